sensor_ctrl: RTL and testbench

Sensor controller sitting directly downstream of the AHB sensor wrapper. It takes the wrapper's `sctrl_en`, `sctrl_clear` and `sctrl_addr` controls, handshakes samples out of the external sensor, and stores them in a 2^ADDRWIDTH-entry buffer. The wrapper reads the buffer back through `sctrl_out`. When the buffer fills, the block raises `sctrl_interrupt` to the CPU.

---
 rtl/sctrl_pkg.sv | 11 +
 rtl/sctrl_mem.sv | 31 +++
 rtl/sensor_ctrl.sv | 77 +++++++
 tb/tb_sensor_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sctrl_pkg.sv
// Shared types and default sizing for the sensor controller.
package sctrl_pkg;
  localparam int SCTRL_ADDRWIDTH = 6;
  localparam int SCTRL_DATAWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } sctrl_state_t;
endpackage

// File: rtl/sctrl_mem.sv
// Sample buffer: one synchronous write port, one asynchronous read port,
// contents cleared only by HRESETn.
module sctrl_mem
  import sctrl_pkg::*;
#(
  parameter int ADDRWIDTH = SCTRL_ADDRWIDTH,
  parameter int DATAWIDTH = SCTRL_DATAWIDTH
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [DATAWIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle read of the write target sees the pre-edge value.
  assign rdata = mem[raddr];
endmodule

// File: rtl/sensor_ctrl.sv
// Sensor acquisition controller: requests samples while enabled, fills the
// buffer, and holds an interrupt once the buffer is full until cleared.
module sensor_ctrl
  import sctrl_pkg::*;
#(
  parameter int ADDRWIDTH = SCTRL_ADDRWIDTH,
  parameter int DATAWIDTH = SCTRL_DATAWIDTH
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 sctrl_en,
  input  logic                 sctrl_clear,
  input  logic [ADDRWIDTH-1:0] sctrl_addr,
  output logic [DATAWIDTH-1:0] sctrl_out,
  output logic                 sctrl_interrupt,
  output logic                 sensor_en,
  input  logic                 sensor_ready,
  input  logic [DATAWIDTH-1:0] sensor_out
);
  sctrl_state_t          state, state_nxt;
  logic [ADDRWIDTH-1:0]  wptr, wptr_nxt;
  logic                  we;

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    we        = 1'b0;
    if (sctrl_clear) begin
      // Clear beats any simultaneous sample; buffer contents are kept.
      state_nxt = IDLE;
      wptr_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: if (sctrl_en) state_nxt = REQ;
        REQ: begin
          if (!sctrl_en) begin
            state_nxt = IDLE;
          end else if (sensor_ready) begin
            we       = 1'b1;
            wptr_nxt = wptr + 1'b1;
            if (wptr == '1) state_nxt = FULL;
          end
        end
        FULL:    state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state           <= IDLE;
      wptr            <= '0;
      sctrl_interrupt <= 1'b0;
    end else begin
      state           <= state_nxt;
      wptr            <= wptr_nxt;
      sctrl_interrupt <= (state_nxt == FULL);
    end
  end

  // Decoded from state so an async reset drops the request immediately.
  assign sensor_en = (state == REQ);

  sctrl_mem #(
    .ADDRWIDTH(ADDRWIDTH),
    .DATAWIDTH(DATAWIDTH)
  ) u_mem (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .we      (we),
    .waddr   (wptr),
    .wdata   (sensor_out),
    .raddr   (sctrl_addr),
    .rdata   (sctrl_out)
  );
endmodule

// File: tb/tb_sensor_ctrl.sv
// Randomized and directed bench for sensor_ctrl against a behavioural buffer model.
module tb_sensor_ctrl;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          sctrl_en, sctrl_clear, sensor_ready;
  logic [AW-1:0] sctrl_addr;
  logic [DW-1:0] sctrl_out, sensor_out;
  logic          sctrl_interrupt, sensor_en;

  sensor_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .sctrl_en       (sctrl_en),
    .sctrl_clear    (sctrl_clear),
    .sctrl_addr     (sctrl_addr),
    .sctrl_out      (sctrl_out),
    .sctrl_interrupt(sctrl_interrupt),
    .sensor_en      (sensor_en),
    .sensor_ready   (sensor_ready),
    .sensor_out     (sensor_out)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: buffer contents, next slot, "requesting" and "full" flags.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_wp;
  bit            m_req, m_full;
  int            n_vec, n_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_wp = 0; m_req = 0; m_full = 0;
  endtask

  task automatic model_edge();
    if (sctrl_clear) begin
      m_wp = 0; m_req = 0; m_full = 0;
    end else if (m_full) begin
      // waits for clear
    end else if (!m_req) begin
      if (sctrl_en) m_req = 1;
    end else if (!sctrl_en) begin
      m_req = 0;
    end else if (sensor_ready) begin
      m_mem[m_wp] = sensor_out;
      if (m_wp == DEPTH - 1) begin
        m_full = 1; m_req = 0; m_wp = 0;
      end else begin
        m_wp++;
      end
    end
  endtask

  task automatic cyc(input logic en, input logic clr, input logic rdy,
                     input logic [DW-1:0] d, input logic [AW-1:0] a);
    sctrl_en = en; sctrl_clear = clr; sensor_ready = rdy; sensor_out = d; sctrl_addr = a;
    #1 chk("rd_pre", sctrl_out, m_mem[a]);
    @(posedge HCLK);
    model_edge();
    #1;
    chk("sensor_en", {31'd0, sensor_en}, {31'd0, m_req});
    chk("irq", {31'd0, sctrl_interrupt}, {31'd0, m_full});
    chk("rd", sctrl_out, m_mem[a]);
  endtask

  int k, n;

  initial begin
    n_vec = 0; n_err = 0;
    HRESETn = 1'b0;
    sctrl_en = 0; sctrl_clear = 0; sensor_ready = 0; sensor_out = '0; sctrl_addr = '0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_sensor_en", {31'd0, sensor_en}, 32'd0);
    chk("rst_irq", {31'd0, sctrl_interrupt}, 32'd0);
    chk("rst_out", sctrl_out, 32'd0);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Idle read-back of the whole buffer.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 0, '0, AW'(i));
      chk("idle_zero", sctrl_out, 32'd0);
    end

    // Full fill with continuous ready.
    k = 0;
    while (!m_full && k < 200) begin
      cyc(1, 0, 1, 32'h1000 + m_wp, '0);
      k++;
    end
    chk("fill_cycles", k, 65);   // 1 cycle to raise sensor_en + 64 writes
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, $urandom, AW'(i));
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, $urandom_range(0, 1), $urandom, AW'(i));
      chk("fill_data", sctrl_out, 32'h1000 + i);
    end

    // Clear out of FULL with enable held; old data survives until overwritten.
    cyc(1, 1, 0, '0, 6'd5);
    chk("clr_irq", {31'd0, sctrl_interrupt}, 32'd0);
    cyc(1, 0, 0, '0, 6'd5);
    chk("clr_reenter", {31'd0, sensor_en}, 32'd1);
    chk("clr_old", sctrl_out, 32'h1005);

    // Sparse handshake.
    k = 0; n = 0;
    while (!m_full && k < 400) begin
      if (k % 3 == 2) n++;
      cyc(1, 0, (k % 3 == 2), 32'hA5A50000 + m_wp, AW'(k));
      k++;
    end
    chk("sparse_cnt", n, 64);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 0, '0, AW'(i));
      chk("sparse_data", sctrl_out, 32'hA5A50000 + i);
    end

    // Clear colliding with a sample at wptr=10.
    cyc(0, 1, 0, '0, '0);
    k = 0;
    while (m_wp != 10 && k < 50) begin cyc(1, 0, 1, $urandom, '0); k++; end
    cyc(1, 1, 1, 32'hDEADBEEF, 6'd10);
    chk("collide_keep", sctrl_out, 32'hA5A5000A);
    cyc(1, 0, 0, '0, '0);
    cyc(1, 0, 1, 32'h0BAD0000, 6'd0);
    chk("collide_restart", sctrl_out, 32'h0BAD0000);

    // Disable mid-run: 20 samples, 5-cycle gap, 44 more to FULL.
    cyc(0, 1, 0, '0, '0);
    k = 0;
    while (m_wp != 20 && k < 60) begin cyc(1, 0, 1, 32'h2000 + m_wp, '0); k++; end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, $urandom, 6'd20);
      chk("gap_sensor_en", {31'd0, sensor_en}, 32'd0);
    end
    k = 0; n = 0;
    while (!m_full && k < 200) begin
      if (sensor_en) n++;
      cyc(1, 0, 1, 32'h2000 + m_wp, 6'd20);
      k++;
    end
    chk("resume_cnt", n, 44);
    chk("resume_idx", sctrl_out, 32'h2014);

    // Async reset mid-REQ at wptr=30.
    cyc(0, 1, 0, '0, '0);
    k = 0;
    while (m_wp != 30 && k < 60) begin cyc(1, 0, 1, $urandom, '0); k++; end
    #2 HRESETn = 1'b0;
    #1;
    chk("arst_sensor_en", {31'd0, sensor_en}, 32'd0);
    chk("arst_irq", {31'd0, sctrl_interrupt}, 32'd0);
    chk("arst_out", sctrl_out, 32'd0);
    model_reset();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, '0, AW'(i));
    cyc(1, 0, 0, '0, '0);
    cyc(1, 0, 1, 32'h33330000, 6'd0);
    chk("arst_restart", sctrl_out, 32'h33330000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a = ($urandom % 4 == 0) ? AW'(m_wp) : AW'($urandom);
      cyc(($urandom % 8) != 0, ($urandom % 60) == 0, $urandom % 2, $urandom, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
